// File: rtl/n64_pi_pkg.sv
// n64_pi_pkg: shared PI state encoding, phase timing defaults and address map constants
package n64_pi_pkg;
  typedef enum logic [2:0] {IDLE, ADDR_H, ADDR_L, GAP, STROBE_LO, STROBE_HI} pi_state_t;
  localparam int T_ALE_DEF = 4;
  localparam int T_LO_DEF = 6;
  localparam int T_HI_DEF = 4;
  localparam logic [31:0] PI_ADDR_CART_HI = 32'h1E40_0000;
  localparam logic [31:0] PI_ADDR_CART_EC = 32'h1EC0_0000;
  localparam logic [31:0] PI_ADDR_ROM_IPL = 32'h1040_0400;
  function automatic logic [7:0] phase_len(input int cycles);
    return 8'(cycles - 1);
  endfunction
endpackage

// File: rtl/pi_phase_timer.sv
// pi_phase_timer: loadable down-counter; done while the count sits at zero
module pi_phase_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [7:0] value,
  output logic       done
);
  logic [7:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= 8'd0;
    else if (load) cnt <= value;
    else if (cnt != 8'd0) cnt <= cnt - 8'd1;
  assign done = cnt == 8'd0;
endmodule

// File: rtl/n64_pi_master.sv
// n64_pi_master: N64 parallel-interface bus master issuing multi-word read/write bursts
module n64_pi_master
  import n64_pi_pkg::*;
#(
  parameter int T_ALE = T_ALE_DEF,
  parameter int T_LO  = T_LO_DEF,
  parameter int T_HI  = T_HI_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [7:0]  cmd_len,
  input  logic [15:0] wr_data,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic [15:0] ad_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic        aleh,
  output logic        alel,
  output logic        read,
  output logic        write,
  output logic        busy
);
  pi_state_t state, state_n;
  logic [31:0] addr;
  logic [7:0] len_cnt, tval;
  logic [15:0] wdata;
  logic dir, armed, done, tload, rd_take;
  pi_phase_timer u_timer (
    .clk(clk),
    .reset(reset),
    .load(tload),
    .value(tval),
    .done(done)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:      if (cmd_valid && cmd_ready) state_n = ADDR_H;
      ADDR_H:    if (done) state_n = ADDR_L;
      ADDR_L:    if (done) state_n = GAP;
      GAP:       if (done && (!dir || wr_valid)) state_n = STROBE_LO;
      STROBE_LO: if (done) state_n = STROBE_HI;
      STROBE_HI: if (done && len_cnt == 8'd0) state_n = IDLE;
                 else if (done && (!dir || wr_valid)) state_n = STROBE_LO;
      default:   state_n = IDLE;
    endcase
  end
  // every state change reloads the timer with the duration of the state being entered
  assign tload = state_n != state;
  assign tval = state_n == STROBE_LO ? phase_len(T_LO) : state_n == STROBE_HI ? phase_len(T_HI) : phase_len(T_ALE);
  assign rd_take = state == STROBE_LO && state_n == STROBE_HI && !dir;
  always_comb begin
    cmd_ready = state == IDLE && armed;
    busy = state != IDLE;
    aleh = state == ADDR_H;
    alel = state == ADDR_H || state == ADDR_L;
    read = !(state == STROBE_LO && !dir);
    write = !(state == STROBE_LO && dir);
    ad_oe = state == ADDR_H || state == ADDR_L || (state != IDLE && dir);
    ad_out = state == ADDR_H ? addr[31:16] : state == ADDR_L ? addr[15:0] & 16'hFFFE : (state != IDLE && dir) ? wdata : 16'h0;
    wr_ready = dir && state_n == STROBE_LO && state != STROBE_LO;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      armed <= 1'b0;
      addr <= 32'h0;
      len_cnt <= 8'd0;
      dir <= 1'b0;
      wdata <= 16'h0;
      rd_data <= 16'h0;
      rd_valid <= 1'b0;
    end else begin
      armed <= 1'b1;
      rd_valid <= rd_take;
      if (rd_take) rd_data <= ad_in;
      if (cmd_valid && cmd_ready) begin
        addr <= cmd_addr;
        len_cnt <= cmd_len;
        dir <= cmd_write;
      end
      if (wr_ready) wdata <= wr_data;
      if (state == STROBE_HI && state_n == STROBE_LO) len_cnt <= len_cnt - 8'd1;
    end
endmodule

// File: tb/tb_n64_pi_master.sv
// tb_n64_pi_master: directed PI bursts checked against a phase-level behavioural model
module tb_n64_pi_master;
  localparam int T_ALE = 4;
  localparam int T_LO = 6;
  localparam int T_HI = 4;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0, cmd_write = 1'b0, wr_valid = 1'b0;
  logic [31:0] cmd_addr = 32'h0;
  logic [7:0] cmd_len = 8'h0;
  logic [15:0] wr_data = 16'h0;
  logic [15:0] rsp_word = 16'hA55A;
  logic cmd_ready, wr_ready, rd_valid, ad_oe, aleh, alel, read, write, busy;
  logic [15:0] rd_data, ad_out, ad_in;
  int n_chk = 0, n_err = 0;
  n64_pi_master dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .ad_in(ad_in), .ad_out(ad_out),
    .ad_oe(ad_oe), .aleh(aleh), .alel(alel), .read(read), .write(write), .busy(busy)
  );
  always #5 clk = ~clk;
  // responder: presents a new word after each completed read strobe
  assign ad_in = rsp_word;
  always @(posedge read) if (!reset) rsp_word <= rsp_word + 16'h1111;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, req, $time);
    end
  endtask

  logic e_ah, e_al, e_rd, e_wr, e_oe, e_busy, e_rdy, e_rdv, e_achk, e_ww, ab;
  logic [15:0] e_ado, e_rdd, cap;

  function automatic void set_idle(input logic rdy);
    e_ah = 0; e_al = 0; e_rd = 1; e_wr = 1; e_oe = 0; e_busy = 0; e_rdy = rdy;
    e_rdv = 0; e_achk = 1; e_ado = 16'h0; e_ww = 0;
  endfunction

  task automatic cyc(input logic ah, al, rd, wr, oe, achk, input logic [15:0] ado, input logic ww, rdv, cp);
    e_ah = ah; e_al = al; e_rd = rd; e_wr = wr; e_oe = oe; e_achk = achk; e_ado = ado;
    e_ww = ww; e_rdv = rdv; e_busy = 1; e_rdy = 0;
    if (rdv) e_rdd = cap;
    if (cp) begin @(negedge clk); cap = ad_in; end
    @(posedge clk or posedge reset);
    if (reset) ab = 1;
  endtask

  task automatic run_cmd(input logic w, input logic [31:0] a, input logic [7:0] l);
    logic [15:0] wd;
    ab = 0;
    for (int i = 0; i < T_ALE && !ab; i++) cyc(1, 1, 1, 1, 1, 1, a[31:16], 0, 0, 0);
    for (int i = 0; i < T_ALE && !ab; i++) cyc(0, 1, 1, 1, 1, 1, {a[15:1], 1'b0}, 0, 0, 0);
    for (int i = 0; i < T_ALE && !ab; i++) cyc(0, 0, 1, 1, w, 0, 16'h0, w && i == T_ALE - 1, 0, 0);
    for (int k = 0; k <= int'(l) && !ab; k++) begin
      while (w && !ab && !wr_valid) cyc(0, 0, 1, 1, 1, 0, 16'h0, 1, 0, 0);
      wd = wr_data;
      for (int i = 0; i < T_LO && !ab; i++) cyc(0, 0, w, !w, w, w, wd, 0, 0, !w && i == T_LO - 1);
      for (int i = 0; i < T_HI && !ab; i++)
        cyc(0, 0, 1, 1, w, 0, 16'h0, w && k < int'(l) && i == T_HI - 1, !w && i == 0, 0);
    end
  endtask

  initial begin
    ab = 0; cap = 16'h0; e_rdd = 16'h0; set_idle(0);
    forever begin
      if (reset) begin
        set_idle(0); e_rdd = 16'h0;
        @(negedge reset);
        @(posedge clk);
      end
      set_idle(1);
      @(posedge clk or posedge reset);
      if (!reset && cmd_valid) run_cmd(cmd_write, cmd_addr, cmd_len);
    end
  end

  int n_rds = 0, n_rdv = 0, n_aleh = 0, n_wrr = 0, n_wrs = 0, n_acc = 0, n_wbad = 0;
  int lo_cur = 0, last_lo = 0, wlo_cur = 0, last_wlo = 0;
  logic [15:0] last_adh = 0, last_adl = 0, last_wad = 0, wad0 = 0;
  logic prv_read = 1, prv_write = 1, prv_aleh = 0;

  always @(negedge clk) begin
    if (reset) begin
      chk("reset_outputs", {aleh, alel, read, write, ad_oe, busy, cmd_ready, rd_valid, wr_ready}, 9'b001100000);
      chk("reset_ad_out", ad_out, 16'h0);
      chk("reset_rd_data", rd_data, 16'h0);
      lo_cur = 0; wlo_cur = 0;
    end else begin
      chk("aleh", aleh, e_ah);
      chk("alel", alel, e_al);
      chk("read", read, e_rd);
      chk("write", write, e_wr);
      chk("ad_oe", ad_oe, e_oe);
      chk("busy", busy, e_busy);
      chk("cmd_ready", cmd_ready, e_rdy);
      chk("rd_valid", rd_valid, e_rdv);
      chk("rd_data", rd_data, e_rdd);
      chk("wr_ready", wr_ready, e_ww && wr_valid);
      if (e_achk) chk("ad_out", ad_out, e_ado);
      chk("strobe_overlap", !read && !write, 0);
      chk("strobe_during_ale", (aleh || alel) && (!read || !write), 0);
      if (prv_read && !read) n_rds++;
      if (prv_write && !write) begin n_wrs++; wad0 = ad_out; end
      if (!prv_aleh && aleh) n_aleh++;
      if (rd_valid) n_rdv++;
      if (wr_ready) n_wrr++;
      if (cmd_valid && cmd_ready) n_acc++;
      if (aleh) last_adh = ad_out;
      if (alel && !aleh) last_adl = ad_out;
      if (!read) lo_cur++;
      else if (lo_cur != 0) begin last_lo = lo_cur; lo_cur = 0; end
      if (!write) begin
        wlo_cur++; last_wad = ad_out;
        if (ad_out !== wad0) n_wbad++;
      end else if (wlo_cur != 0) begin last_wlo = wlo_cur; wlo_cur = 0; end
    end
    prv_read = read; prv_write = write; prv_aleh = aleh;
  end

  int s_rds, s_rdv, s_aleh, s_wrr, s_wrs, s_acc, s_wbad;
  task automatic snap();
    s_rds = n_rds; s_rdv = n_rdv; s_aleh = n_aleh; s_wrr = n_wrr; s_wrs = n_wrs; s_acc = n_acc; s_wbad = n_wbad;
  endtask

  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [7:0] l, input logic keep);
    int t;
    @(posedge clk); #2;
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_len = l;
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 5000) begin @(negedge clk); t++; end
    chk("cmd_accept_in_time", t < 5000, 1);
    @(posedge clk); #2;
    if (!keep) cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (busy && t < 5000) begin @(negedge clk); t++; end
    chk("burst_done_in_time", t < 5000, 1);
  endtask

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk); chk("rdy_before_first_edge", cmd_ready, 0);
    @(negedge clk); chk("rdy_after_first_edge", cmd_ready, 1);
    // single-word read
    snap(); send_cmd(0, 32'h1EC0_0000, 8'd0, 0); wait_idle();
    chk("r1_addr_hi", last_adh, 16'h1EC0);
    chk("r1_addr_lo", last_adl, 16'h0000);
    chk("r1_strobes", n_rds - s_rds, 1);
    chk("r1_low_len", last_lo, 6);
    chk("r1_rd_data", rd_data, 16'hA55A);
    chk("r1_rd_valids", n_rdv - s_rdv, 1);
    // four-word read
    snap(); send_cmd(0, 32'h1EC0_0010, 8'd3, 0); wait_idle();
    chk("r4_strobes", n_rds - s_rds, 4);
    chk("r4_rd_valids", n_rdv - s_rdv, 4);
    chk("r4_addr_phases", n_aleh - s_aleh, 1);
    chk("r4_addr_lo", last_adl, 16'h0010);
    chk("r4_last_word", rd_data, 16'hE99E);
    // single-word write
    wr_data = 16'h001E; wr_valid = 1;
    snap(); send_cmd(1, 32'h1040_0400, 8'd0, 0); wait_idle();
    @(posedge clk); #2 wr_valid = 0;
    chk("w1_ad_out", last_wad, 16'h001E);
    chk("w1_ad_unstable", n_wbad - s_wbad, 0);
    chk("w1_wr_ready", n_wrr - s_wrr, 1);
    chk("w1_strobes", n_wrs - s_wrs, 1);
    chk("w1_low_len", last_wlo, 6);
    chk("w1_addr", {last_adh, last_adl}, 32'h1040_0400);
    // two-word write with the stream stalled before word 2
    wr_data = 16'h1111; wr_valid = 1;
    snap(); send_cmd(1, 32'h1040_0800, 8'd1, 0);
    t = 0;
    while (n_wrr - s_wrr < 1 && t < 200) begin @(negedge clk); t++; end
    chk("w2_first_ready_in_time", t < 200, 1);
    @(posedge clk); #2 wr_valid = 0; wr_data = 16'h2222;
    repeat (20) @(negedge clk);
    chk("w2_stalled_strobes", n_wrs - s_wrs, 1);
    chk("w2_stalled_write_high", write, 1);
    chk("w2_stalled_busy", busy, 1);
    @(posedge clk); #2 wr_valid = 1;
    wait_idle();
    @(posedge clk); #2 wr_valid = 0;
    chk("w2_strobes", n_wrs - s_wrs, 2);
    chk("w2_wr_ready", n_wrr - s_wrr, 2);
    chk("w2_second_word", last_wad, 16'h2222);
    // cmd_valid held through a burst; second command with odd address
    snap(); send_cmd(0, 32'h1EC0_0000, 8'd1, 1); send_cmd(0, 32'h1E40_0001, 8'd0, 0); wait_idle();
    chk("b2b_accepts", n_acc - s_acc, 2);
    chk("b2b_addr_phases", n_aleh - s_aleh, 2);
    chk("b2b_addr_hi", last_adh, 16'h1E40);
    chk("b2b_addr_lo_odd", last_adl, 16'h0000);
    chk("b2b_strobes", n_rds - s_rds, 3);
    // reset during the second strobe of an eight-word read
    snap(); send_cmd(0, 32'h1EC0_0000, 8'd7, 0);
    t = 0;
    while (n_rds - s_rds < 2 && t < 200) begin @(negedge clk); t++; end
    chk("abort_reach_strobe2", t < 200, 1);
    #1 reset = 1;
    #1 chk("abort_read_high", read, 1);
    chk("abort_busy_low", busy, 0);
    chk("abort_rdv_before", n_rdv - s_rdv, 1);
    repeat (2) @(posedge clk);
    #2 reset = 0;
    @(negedge clk); chk("abort_rdy_before_edge", cmd_ready, 0);
    @(negedge clk); chk("abort_rdy_after_edge", cmd_ready, 1);
    repeat (60) @(negedge clk);
    chk("abort_no_more_rdv", n_rdv - s_rdv, 1);
    chk("abort_no_more_strobes", n_rds - s_rds, 2);
    // maximum burst length
    snap(); send_cmd(0, 32'h1EC0_0100, 8'd255, 0); wait_idle();
    chk("r256_strobes", n_rds - s_rds, 256);
    chk("r256_rd_valids", n_rdv - s_rdv, 256);
    chk("r256_addr_phases", n_aleh - s_aleh, 1);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
